// File: rtl/imm_pkg.sv
// Shared opcodes, immediate format codes and occupancy states for the
// decode-stage immediate generator.
package imm_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_R  = 3'd0,
      IMM_I  = 3'd1,
      IMM_SH = 3'd2,
      IMM_S  = 3'd3,
      IMM_B  = 3'd4,
      IMM_U  = 3'd5,
      IMM_J  = 3'd6,
      IMM_Z  = 3'd7
   } imm_fmt_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // Only RV32 and RV64 datapaths are supported.
   function automatic bit xlen_legal(int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: raw instruction -> extended
// immediate, format code and illegal flag.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   localparam bit RV64 = (XLEN == 64);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            is_shift;
   logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm, sh_imm, z_imm;

   assign opc      = instr[6:0];
   assign f3       = instr[14:12];
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   // Signed casts widen with sign extension; U is sign-extended on RV64 too.
   assign i_imm = XLEN'($signed(instr[31:20]));
   assign s_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign b_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   assign j_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
   assign u_imm = XLEN'($signed({instr[31:12], 12'b0}));
   assign z_imm = XLEN'(instr[19:15]);

   // Shift amount is one bit wider on RV64.
   generate
      if (RV64) begin : g_sh64
         assign sh_imm = XLEN'(instr[25:20]);
      end else begin : g_sh32
         assign sh_imm = XLEN'(instr[24:20]);
      end
   endgenerate

   // Select the immediate by opcode; unknown encodings are illegal with imm=0.
   always_comb begin
      imm     = '0;
      fmt     = IMM_R;
      illegal = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opc)
            OPC_LOAD, OPC_JALR: begin
               imm = i_imm; fmt = IMM_I;
            end
            OPC_OP_IMM: begin
               if (is_shift) begin imm = sh_imm; fmt = IMM_SH; end
               else          begin imm = i_imm;  fmt = IMM_I;  end
            end
            OPC_OP_IMM32: begin
               if (!RV64)         illegal = 1'b1;
               else if (is_shift) begin imm = sh_imm; fmt = IMM_SH; end
               else               begin imm = i_imm;  fmt = IMM_I;  end
            end
            OPC_STORE:  begin imm = s_imm; fmt = IMM_S; end
            OPC_BRANCH: begin imm = b_imm; fmt = IMM_B; end
            OPC_JAL:    begin imm = j_imm; fmt = IMM_J; end
            OPC_LUI, OPC_AUIPC: begin imm = u_imm; fmt = IMM_U; end
            OPC_OP: ;
            OPC_OP32: begin
               if (!RV64) illegal = 1'b1;
            end
            OPC_SYSTEM: begin
               if (f3[2]) begin imm = z_imm; fmt = IMM_Z; end
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-stage immediate generator: decodes at the input, holds results in
// a MAIN/SKID pair so in_ready can be a flop, and counts illegal accepts.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ILL_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [XLEN-1:0]      in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [XLEN-1:0]      out_pc,
   output logic [XLEN-1:0]      out_imm,
   output logic [2:0]           out_fmt,
   output logic [XLEN-1:0]      out_target,
   output logic                 out_illegal,
   output logic [ILL_CNT_W-1:0] ill_count
);

   generate
      if (!xlen_legal(XLEN)) begin : g_bad_xlen
         $error("imm_decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      imm_fmt_e        fmt;
      logic            illegal;
   } entry_t;

   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   logic            dec_ill;
   entry_t          in_ent, main_q, skid_q;
   occ_e            occ_q, occ_d;
   logic            in_xfer, out_xfer;
   logic            ld_main_in, ld_main_skid, ld_skid;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   // Target is formed before the register so the output path is flop-only.
   assign in_ent = '{instr:   in_instr,
                     pc:      in_pc,
                     imm:     dec_imm,
                     target:  in_pc + dec_imm,
                     fmt:     dec_fmt,
                     illegal: dec_ill};

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = (occ_q != OCC_EMPTY) && out_ready;

   // Occupancy next-state and MAIN/SKID load selects; flush wins over all.
   always_comb begin
      occ_d        = occ_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (in_xfer) begin ld_main_in = 1'b1; occ_d = OCC_ONE; end
            end
            OCC_ONE: begin
               if (in_xfer && out_xfer) ld_main_in = 1'b1;
               else if (in_xfer)        begin ld_skid = 1'b1; occ_d = OCC_TWO; end
               else if (out_xfer)       occ_d = OCC_EMPTY;
            end
            OCC_TWO: begin
               // in_ready is low here, so only a drain can happen.
               if (out_xfer) begin ld_main_skid = 1'b1; occ_d = OCC_ONE; end
            end
            default: occ_d = OCC_EMPTY;
         endcase
      end
   end

   // Occupancy register; in_ready tracks whether SKID will be free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q    <= OCC_EMPTY;
         in_ready <= 1'b0;
      end else begin
         occ_q    <= occ_d;
         in_ready <= (occ_d != OCC_TWO);
      end
   end

   // MAIN/SKID payload registers; contents are left as-is on flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (ld_main_in)        main_q <= in_ent;
         else if (ld_main_skid) main_q <= skid_q;
         if (ld_skid)           skid_q <= in_ent;
      end
   end

   // Saturating count of illegal instructions that were actually kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ill_count <= '0;
      end else if (in_xfer && dec_ill && !flush && (ill_count != '1)) begin
         ill_count <= ill_count + ILL_CNT_W'(1);
      end
   end

   assign out_valid   = (occ_q != OCC_EMPTY);
   assign out_instr   = main_q.instr;
   assign out_pc      = main_q.pc;
   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_target  = main_q.target;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: driver pushes expected results on
// accept, a negedge monitor pops and compares on every output transfer.
module tb_imm_decode_stage;

   localparam int XLEN      = 32;
   localparam int ILL_CNT_W = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 flush = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [31:0]          in_instr = '0;
   logic [XLEN-1:0]      in_pc = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [31:0]          out_instr;
   logic [XLEN-1:0]      out_pc;
   logic [XLEN-1:0]      out_imm;
   logic [2:0]           out_fmt;
   logic [XLEN-1:0]      out_target;
   logic                 out_illegal;
   logic [ILL_CNT_W-1:0] ill_count;

   imm_decode_stage #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_target(out_target), .out_illegal(out_illegal), .ill_count(ill_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic [31:0] target;
      logic        ill;
   } vec_t;

   vec_t exp_q[$];
   vec_t vecs[11];
   vec_t ills[4];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Offer one instruction; the expectation is queued when acceptance is seen.
   task automatic send(input vec_t v);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_instr = v.instr; in_pc = v.pc;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) begin exp_q.push_back(v); ok = 1'b1; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain();
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
      #1;
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every output transfer must match the head of the scoreboard.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", {32'd0, out_instr}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("instr",   64'(out_instr),   64'(e.instr));
               chk("pc",      64'(out_pc),      64'(e.pc));
               chk("imm",     64'(out_imm),     64'(e.imm));
               chk("fmt",     64'(out_fmt),     64'(e.fmt));
               chk("target",  64'(out_target),  64'(e.target));
               chk("illegal", 64'(out_illegal), 64'(e.ill));
            end
         end
      end
   end

   initial begin
      //              instr         pc            imm           fmt   target        ill
      vecs[0]  = '{32'hFFF00093, 32'h00000000, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 1'b0}; // ADDI -1
      vecs[1]  = '{32'hFE000EE3, 32'h00000100, 32'hFFFFFFFC, 3'd4, 32'h000000FC, 1'b0}; // BEQ -4
      vecs[2]  = '{32'h123452B7, 32'h00000200, 32'h12345000, 3'd5, 32'h12345200, 1'b0}; // LUI
      vecs[3]  = '{32'h4030D093, 32'h00000010, 32'h00000003, 3'd2, 32'h00000013, 1'b0}; // SRAI 3
      vecs[4]  = '{32'h3002D073, 32'h00000000, 32'h00000005, 3'd7, 32'h00000005, 1'b0}; // CSRRWI zimm=5
      vecs[5]  = '{32'hFE20AC23, 32'h00000000, 32'hFFFFFFF8, 3'd3, 32'hFFFFFFF8, 1'b0}; // SW -8
      vecs[6]  = '{32'h008000EF, 32'h00001000, 32'h00000008, 3'd6, 32'h00001008, 1'b0}; // JAL +8
      vecs[7]  = '{32'h002081B3, 32'h00000300, 32'h00000000, 3'd0, 32'h00000300, 1'b0}; // ADD
      vecs[8]  = '{32'hFFFFF117, 32'h00002000, 32'hFFFFF000, 3'd5, 32'h00001000, 1'b0}; // AUIPC wrap
      vecs[9]  = '{32'h00000073, 32'h00000004, 32'h00000000, 3'd0, 32'h00000004, 1'b0}; // ECALL
      vecs[10] = '{32'h7FF0A283, 32'h00000000, 32'h000007FF, 3'd1, 32'h000007FF, 1'b0}; // LW +2047
      ills[0]  = '{32'hFFFFFFFF, 32'h00000040, 32'h00000000, 3'd0, 32'h00000040, 1'b1};
      ills[1]  = '{32'h00000010, 32'h00000044, 32'h00000000, 3'd0, 32'h00000044, 1'b1};
      ills[2]  = '{32'h0000007F, 32'h00000048, 32'h00000000, 3'd0, 32'h00000048, 1'b1};
      ills[3]  = '{32'h00000001, 32'h0000004C, 32'h00000000, 3'd0, 32'h0000004C, 1'b1};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'({out_instr, out_imm} | {32'd0, out_pc | out_target}), 64'd0);
      chk("rst_fmt_ill",   64'({out_fmt, out_illegal, ill_count}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_pre_edge", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("in_ready_post_edge", 64'(in_ready), 64'd1);

      // Back-to-back stream, downstream always ready.
      out_ready = 1'b1;
      send(vecs[0]);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      for (int i = 1; i < 11; i++) send(vecs[i]);
      drain();

      // Backpressure: A,B fill MAIN/SKID, C waits, then all drain in order.
      out_ready = 1'b0;
      fork
         begin send(vecs[1]); send(vecs[6]); send(vecs[8]); end
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_head",     64'(out_instr), 64'(vecs[1].instr));
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush with ONE held and a same-cycle illegal accept.
      out_ready = 1'b0;
      send(vecs[2]);
      in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h0; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      exp_q.delete();
      chk("flush1_out_valid", 64'(out_valid), 64'd0);
      chk("flush1_in_ready",  64'(in_ready),  64'd1);
      chk("flush1_ill_count", 64'(ill_count), 64'd0);

      // Flush with TWO held and an offer pending.
      send(vecs[3]); send(vecs[4]);
      in_valid = 1'b1; in_instr = 32'h00000010; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      exp_q.delete();
      chk("flush2_out_valid", 64'(out_valid), 64'd0);
      chk("flush2_in_ready",  64'(in_ready),  64'd1);
      chk("flush2_ill_count", 64'(ill_count), 64'd0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_nothing_out", 64'(out_valid), 64'd0);

      // Illegal instructions and counter saturation at 2 bits.
      send(ills[0]); send(ills[1]);
      drain();
      chk("ill_count_2", 64'(ill_count), 64'd2);
      send(ills[2]); send(ills[3]);
      drain();
      chk("ill_count_sat", 64'(ill_count), 64'd3);

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      send(vecs[5]); send(vecs[7]);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      chk("rst2_valid_ready", 64'({out_valid, in_ready}), 64'd0);
      chk("rst2_data", 64'({out_instr, out_imm} | {32'd0, out_pc | out_target}), 64'd0);
      chk("rst2_fmt_ill", 64'({out_fmt, out_illegal, ill_count}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst2_empty_after", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
